// File: rtl/fifo_rd_packer.sv
// Purpose: reads SIZE-wide entries from a FIFO read port and packs LANES of them into one output word, lane 0 first.
// Latency: each entry lands one cycle after its rd_en; a completed word is registered on the edge that completes it.
// Backpressure: a full accumulator waits for a free output register, and rd_en stays low meanwhile; flush emits a partial word.
module fifo_rd_packer #(
  parameter int SIZE  = 8,
  parameter int LANES = 4,
  localparam int CW   = $clog2(LANES + 1)
) (
  input  logic                  r_clk,
  input  logic                  n_rst,
  input  logic                  e_flag,
  input  logic                  ae_flag,
  input  logic [SIZE-1:0]       fifo_data,
  output logic                  rd_en,
  input  logic                  flush,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [SIZE*LANES-1:0] out_data,
  output logic [CW-1:0]         out_bytes
);

  // r_run holds rd_en off until the first edge after reset release.
  logic                  r_run;
  logic                  r_pend;
  logic                  r_flush_pend;
  logic [CW-1:0]         r_cnt;
  logic [SIZE*LANES-1:0] r_acc;
  logic                  r_out_valid;
  logic [SIZE*LANES-1:0] r_out_data;
  logic [CW-1:0]         r_out_bytes;

  logic [CW-1:0]         w_fill;
  logic                  w_complete;
  logic                  w_out_free;
  logic                  w_load_full;
  logic                  w_load_part;
  logic                  w_flush_clr;
  logic [SIZE*LANES-1:0] w_acc_next;

  // Lanes occupied once the in-flight entry (if any) has landed.
  assign w_fill      = r_cnt + {{(CW-1){1'b0}}, r_pend};
  assign w_complete  = (w_fill == CW'(LANES));
  assign w_out_free  = !r_out_valid || out_ready;
  assign w_load_full = w_complete && w_out_free;
  // A partial word goes out only once no read is in flight, so no entry is split off.
  assign w_load_part = r_flush_pend && !r_pend && (r_cnt != '0) && !w_complete && w_out_free;
  assign w_flush_clr = r_flush_pend && !r_pend && (r_cnt == '0);

  // Read strobe: FIFO not empty, at most one read in flight when almost empty,
  // room for the entry, and no flush outstanding.
  assign rd_en = r_run && !e_flag && (!ae_flag || !r_pend) &&
                 (w_fill < CW'(LANES)) && !r_flush_pend && !flush;

  // Accumulator view including the entry landing this cycle.
  always_comb begin
    w_acc_next = r_acc;
    for (int i = 0; i < LANES; i++) begin
      if (r_pend && (r_cnt == CW'(i))) begin
        w_acc_next[i*SIZE +: SIZE] = fifo_data;
      end
    end
  end

  // Read tracking, lane accumulation and flush bookkeeping.
  always_ff @(posedge r_clk or negedge n_rst) begin
    if (!n_rst) begin
      r_run        <= 1'b0;
      r_pend       <= 1'b0;
      r_flush_pend <= 1'b0;
      r_cnt        <= '0;
      r_acc        <= '0;
    end else begin
      r_run  <= 1'b1;
      r_pend <= rd_en;
      // Clearing the accumulator on every emit keeps unused upper lanes at zero.
      if (w_load_full || w_load_part) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else begin
        r_cnt <= w_fill;
        r_acc <= w_acc_next;
      end
      if (flush) begin
        r_flush_pend <= 1'b1;
      end else if (w_load_part || w_flush_clr) begin
        r_flush_pend <= 1'b0;
      end
    end
  end

  // Output register: loads a full or partial word when free, holds while stalled.
  always_ff @(posedge r_clk or negedge n_rst) begin
    if (!n_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_bytes <= '0;
    end else if (w_load_full) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_acc_next;
      r_out_bytes <= CW'(LANES);
    end else if (w_load_part) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_acc;
      r_out_bytes <= r_cnt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_bytes = r_out_bytes;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer with SIZE=8, LANES=4: FIFO model, scoreboard of expected words,
// table of packing vectors plus hand sequences for backpressure, flush timing and reset.
module tb_fifo_rd_packer;

  localparam int SIZE  = 8;
  localparam int LANES = 4;
  localparam int BW    = 3;

  logic                  r_clk;
  logic                  n_rst;
  logic                  e_flag;
  logic                  ae_flag;
  logic [SIZE-1:0]       fifo_data;
  logic                  rd_en;
  logic                  flush;
  logic                  out_ready;
  logic                  out_valid;
  logic [SIZE*LANES-1:0] out_data;
  logic [BW-1:0]         out_bytes;

  fifo_rd_packer #(.SIZE(SIZE), .LANES(LANES)) dut (
    .r_clk     (r_clk),
    .n_rst     (n_rst),
    .e_flag    (e_flag),
    .ae_flag   (ae_flag),
    .fifo_data (fifo_data),
    .rd_en     (rd_en),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_bytes (out_bytes)
  );

  typedef struct packed {
    logic [2:0]  n;
    logic [31:0] din;
    logic        ae;
    logic        fl;
    logic [31:0] exp_data;
    logic [2:0]  exp_bytes;
    logic [2:0]  exp_run;
  } vec_t;

  typedef struct packed {
    logic [2:0]  bytes;
    logic [31:0] data;
  } exp_t;

  vec_t       vecs [7];
  exp_t       sb   [$];
  logic [7:0] fq   [$];

  int n_checks;
  int n_fail;
  int rd_total;
  int cur_run;
  int max_run;
  logic          prev_rd;
  logic          prev_valid;
  logic          prev_ready;
  logic [31:0]   held_data;
  logic [BW-1:0] held_bytes;

  initial begin
    r_clk = 1'b0;
    forever #5 r_clk = ~r_clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bound_ok(input string name, input bit ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: wait bound expired, expected the DUT to finish within the limit", name);
    end
  endtask

  // FIFO read side: data appears the cycle after rd_en, flags reflect the post-read count.
  task automatic fifo_model();
    e_flag    = 1'b1;
    fifo_data = '0;
    forever begin
      @(posedge r_clk);
      if (rd_en && fq.size() != 0) fifo_data <= fq.pop_front();
      e_flag <= (fq.size() == 0);
    end
  endtask

  // Samples on the falling edge: read rules, output hold, and scoreboard compare on accept.
  task automatic monitor();
    forever begin
      @(negedge r_clk);
      if (n_rst) begin
        if (rd_en) begin
          check("rd_en_while_empty", 64'(e_flag), 64'h0);
          check("fifo_underflow", 64'(fq.size() == 0), 64'h0);
          if (prev_rd) check("ae_read_spacing", 64'(ae_flag), 64'h0);
          rd_total++;
          cur_run++;
          if (cur_run > max_run) max_run = cur_run;
        end else begin
          cur_run = 0;
        end
        if (prev_valid && !prev_ready) begin
          check("hold_valid", 64'(out_valid), 64'h1);
          check("hold_data", 64'(out_data), 64'(held_data));
          check("hold_bytes", 64'(out_bytes), 64'(held_bytes));
        end
        if (out_valid && out_ready) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_word: got data %h bytes %0d, expected no word", out_data, out_bytes);
          end else begin
            exp_t e;
            n_checks--;
            e = sb.pop_front();
            check("word_data", 64'(out_data), 64'(e.data));
            check("word_bytes", 64'(out_bytes), 64'(e.bytes));
          end
        end
        prev_rd    = rd_en;
        prev_valid = out_valid;
        prev_ready = out_ready;
        held_data  = out_data;
        held_bytes = out_bytes;
      end else begin
        prev_rd    = 1'b0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        cur_run    = 0;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (fq.size() != 0 && t < 200) begin
      @(posedge r_clk); #1;
      t++;
    end
    bound_ok(name, t < 200);
  endtask

  task automatic wait_sb(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge r_clk); #1;
      t++;
    end
    bound_ok(name, t < 200);
  endtask

  initial begin
    int   rd_base;
    int   t;
    vec_t v;

    // n entries taken from din lane 0 upward; record 0 holds 21, 503 (low byte 0xF7), 90, 10.
    vecs[0] = '{n:3'd4, din:32'h0A5AF715, ae:1'b0, fl:1'b0, exp_data:32'h0A5AF715, exp_bytes:3'd4, exp_run:3'd4};
    vecs[1] = '{n:3'd3, din:32'h001E1D1C, ae:1'b0, fl:1'b1, exp_data:32'h001E1D1C, exp_bytes:3'd3, exp_run:3'd3};
    vecs[2] = '{n:3'd3, din:32'h00CCBBAA, ae:1'b1, fl:1'b1, exp_data:32'h00CCBBAA, exp_bytes:3'd3, exp_run:3'd1};
    vecs[3] = '{n:3'd1, din:32'h00000001, ae:1'b0, fl:1'b1, exp_data:32'h00000001, exp_bytes:3'd1, exp_run:3'd1};
    vecs[4] = '{n:3'd2, din:32'h00002211, ae:1'b1, fl:1'b1, exp_data:32'h00002211, exp_bytes:3'd2, exp_run:3'd1};
    vecs[5] = '{n:3'd0, din:32'h00000000, ae:1'b0, fl:1'b1, exp_data:32'h00000000, exp_bytes:3'd0, exp_run:3'd0};
    vecs[6] = '{n:3'd4, din:32'h00FF7F80, ae:1'b0, fl:1'b0, exp_data:32'h00FF7F80, exp_bytes:3'd4, exp_run:3'd4};

    n_checks   = 0;
    n_fail     = 0;
    rd_total   = 0;
    cur_run    = 0;
    max_run    = 0;
    prev_rd    = 1'b0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    held_data  = '0;
    held_bytes = '0;
    n_rst      = 1'b1;
    ae_flag    = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b1;

    fork
      fifo_model();
      monitor();
    join_none

    #2 n_rst = 1'b0;
    repeat (2) @(posedge r_clk);
    #1;
    check("reset_rd_en", 64'(rd_en), 64'h0);
    check("reset_out_valid", 64'(out_valid), 64'h0);
    check("reset_out_data", 64'(out_data), 64'h0);
    check("reset_out_bytes", 64'(out_bytes), 64'h0);
    n_rst = 1'b1;
    repeat (2) @(posedge r_clk);
    #1;

    // Table-driven packing vectors.
    for (int k = 0; k < 7; k++) begin
      v       = vecs[k];
      ae_flag = v.ae;
      max_run = 0;
      rd_base = rd_total;
      for (int i = 0; i < int'(v.n); i++) fq.push_back(v.din[8*i +: 8]);
      if (v.exp_bytes != 3'd0) sb.push_back('{bytes: v.exp_bytes, data: v.exp_data});
      wait_drain($sformatf("v%0d_drain", k));
      repeat (3) @(posedge r_clk);
      #1;
      if (v.fl) begin
        flush = 1'b1;
        @(posedge r_clk); #1;
        flush = 1'b0;
      end
      wait_sb($sformatf("v%0d_word", k));
      repeat (4) @(posedge r_clk);
      #1;
      check($sformatf("v%0d_rd_count", k), 64'(rd_total - rd_base), 64'(v.n));
      check($sformatf("v%0d_max_rd_run", k), 64'(max_run), 64'(v.exp_run));
      check($sformatf("v%0d_flush_pend", k), 64'(dut.r_flush_pend), 64'h0);
      ae_flag = 1'b0;
    end

    // Backpressure: 12 entries, downstream stalled for 20 cycles.
    out_ready = 1'b0;
    rd_base   = rd_total;
    for (int i = 0; i < 12; i++) fq.push_back(8'(i));
    sb.push_back('{bytes: 3'd4, data: 32'h03020100});
    sb.push_back('{bytes: 3'd4, data: 32'h07060504});
    sb.push_back('{bytes: 3'd4, data: 32'h0B0A0908});
    repeat (20) @(posedge r_clk);
    #1;
    check("bp_out_valid", 64'(out_valid), 64'h1);
    check("bp_out_data", 64'(out_data), 64'h03020100);
    check("bp_cnt", 64'(dut.r_cnt), 64'h4);
    check("bp_rd_en", 64'(rd_en), 64'h0);
    check("bp_rd_count", 64'(rd_total - rd_base), 64'd8);
    check("bp_words_pending", 64'(sb.size()), 64'd3);
    out_ready = 1'b1;
    wait_sb("bp_release");
    check("bp_fifo_empty", 64'(fq.size()), 64'd0);
    check("bp_rd_total", 64'(rd_total - rd_base), 64'd12);

    // Flush landing on the same edge as a full-word transfer: no partial word follows.
    for (int i = 0; i < 4; i++) fq.push_back(8'(8'h41 + i));
    sb.push_back('{bytes: 3'd4, data: 32'h44434241});
    t = 0;
    while (!(dut.r_pend && dut.r_cnt == 3'd3) && t < 100) begin
      @(negedge r_clk);
      t++;
    end
    bound_ok("fc_reach_last_lane", t < 100);
    flush = 1'b1;
    @(posedge r_clk); #1;
    flush = 1'b0;
    repeat (5) @(posedge r_clk);
    #1;
    check("fc_words_left", 64'(sb.size()), 64'd0);
    check("fc_flush_pend", 64'(dut.r_flush_pend), 64'h0);
    check("fc_out_valid", 64'(out_valid), 64'h0);
    check("fc_cnt", 64'(dut.r_cnt), 64'h0);

    // Reset while two lanes are held and a third entry is in flight.
    for (int i = 0; i < 3; i++) fq.push_back(8'(8'h61 + i));
    t = 0;
    while (!(dut.r_pend && dut.r_cnt == 3'd2) && t < 100) begin
      @(negedge r_clk);
      t++;
    end
    bound_ok("rst_reach_mid_word", t < 100);
    n_rst = 1'b0;
    #1;
    check("rst_rd_en", 64'(rd_en), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_out_bytes", 64'(out_bytes), 64'h0);
    check("rst_cnt", 64'(dut.r_cnt), 64'h0);
    check("rst_pend", 64'(dut.r_pend), 64'h0);
    repeat (2) @(posedge r_clk);
    #1;
    n_rst = 1'b1;
    repeat (2) @(posedge r_clk);
    #1;
    for (int i = 0; i < 4; i++) fq.push_back(8'(8'h71 + i));
    sb.push_back('{bytes: 3'd4, data: 32'h74737271});
    wait_sb("rst_repack");
    check("rst_fifo_empty", 64'(fq.size()), 64'd0);

    repeat (4) @(posedge r_clk);
    #1;
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
